pipe_reg_chain: RTL

Parametrised pipeline register chain with a valid/ready handshake and a per-instance reset/flush load value. It is the successor to the single-stage resettable data register: DEPTH stages of DATA_WIDTH bits, with bubble collapsing, backpressure, synchronous flush and an occupancy count. It sits between core pipeline stages, for example fetch→decode or decode→execute, wherever a stage boundary needs stall and flush support.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_stage.sv | 40 ++++
 rtl/pipe_reg_chain.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline register chain: default payload width and the
// default stage record (valid bit plus payload).
package pipe_pkg;

  localparam int PIPE_DATA_WIDTH = 32;

  typedef struct packed {
    logic                       valid;
    logic [PIPE_DATA_WIDTH-1:0] data;
  } pipe_stage_t;

endpackage

// File: rtl/pipe_stage.sv
// One valid+data pipeline register. Loads clr_val_i on reset or clear and advances on en_i.
// Payload only moves together with a valid entry, so an empty advance keeps the old data.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter type stage_t = pipe_stage_t
) (
  input  logic   clk,
  input  logic   rstn,
  input  logic   clr_i,
  input  stage_t clr_val_i,
  input  logic   en_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t stage_q;
  stage_t stage_d;

  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      stage_d.valid = d_i.valid;
      if (d_i.valid) begin
        stage_d.data = d_i.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr_i) begin
      stage_q <= clr_val_i;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain with bubble collapsing, flush and occupancy count.
// Define PIPE_REG_CHAIN_SKID_EN to add a one-entry skid in front of stage 0 (registered in_ready).
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter  int DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter  int DEPTH      = 2,
  localparam int CNT_W      = $clog2(DEPTH + 2)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_set,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      occupancy
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  stage_t           stage_q  [DEPTH];
  stage_t           stage_in [DEPTH];
  stage_t           clr_val;
  stage_t           in_head;
  stage_t           head;
  logic [DEPTH:0]   ready;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;
  logic             in_xfer;
  logic             out_xfer;

  assign clr_val = '{valid: 1'b0, data: data_set};
  assign in_head = '{valid: in_valid, data: in_data};

  // A stage may advance when it is empty or the stage ahead is advancing.
  always_comb begin
    ready        = '0;
    ready[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready[k] = !stage_q[k].valid || ready[k+1];
    end
  end

`ifdef PIPE_REG_CHAIN_SKID_EN
  stage_t skid_q;
  stage_t skid_d;

  // The held skid entry drains first; new input only lands in the skid when stage 0 is blocked.
  always_comb begin
    skid_d = skid_q;
    if (skid_q.valid) begin
      if (ready[0]) begin
        skid_d.valid = 1'b0;
      end
    end else if (in_valid && !ready[0]) begin
      skid_d.valid = 1'b1;
      skid_d.data  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      skid_q <= clr_val;
    end else begin
      skid_q <= skid_d;
    end
  end

  assign head     = skid_q.valid ? skid_q : in_head;
  assign in_ready = !skid_q.valid;
`else
  assign head     = in_head;
  assign in_ready = ready[0];
`endif

  always_comb begin
    stage_in[0] = head;
    for (int k = 1; k < DEPTH; k++) begin
      stage_in[k] = stage_q[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage #(
      .stage_t (stage_t)
    ) u_stage (
      .clk       (clk),
      .rstn      (rstn),
      .clr_i     (flush),
      .clr_val_i (clr_val),
      .en_i      (ready[k]),
      .d_i       (stage_in[k]),
      .q_o       (stage_q[k])
    );
  end

  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_data  = stage_q[DEPTH-1].data;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q;
    if (in_xfer && !out_xfer) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule
